// File: rtl/core_if_ibuf_pkg.sv
// Types shared by the fetch-to-decode instruction buffer. Supplies the core_defines widths
// (CORE_INST_WIDTH, CORE_PC_WIDTH, CORE_IBUF_ENTRY_WIDTH) when they are not already defined.
`ifndef CORE_INST_WIDTH
`define CORE_INST_WIDTH 32
`endif
`ifndef CORE_PC_WIDTH
`define CORE_PC_WIDTH 32
`endif
`ifndef CORE_IBUF_ENTRY_WIDTH
`define CORE_IBUF_ENTRY_WIDTH (`CORE_INST_WIDTH + `CORE_PC_WIDTH + 1)
`endif

package core_if_ibuf_pkg;

  localparam int unsigned InstWidth  = `CORE_INST_WIDTH;
  localparam int unsigned PcWidth    = `CORE_PC_WIDTH;
  localparam int unsigned EntryWidth = `CORE_IBUF_ENTRY_WIDTH;

  typedef struct packed {
    logic [InstWidth-1:0] inst;
    logic [PcWidth-1:0]   pc;
    logic                 predict;
  } ibuf_entry_t;

  function automatic ibuf_entry_t make_entry(input logic [InstWidth-1:0] inst,
                                             input logic [PcWidth-1:0]   pc,
                                             input logic                 predict);
    ibuf_entry_t e;
    e.inst    = inst;
    e.pc      = pc;
    e.predict = predict;
    return e;
  endfunction

endpackage

// File: rtl/core_if_ibuf.sv
// Instruction buffer between the IFU and decode: a DEPTH-entry FIFO with flush.
// Optional zero-latency bypass of an empty buffer is enabled by CORE_IBUF_BYPASS_EN.
module core_if_ibuf
  import core_if_ibuf_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        valid_in,
  output logic                        ready_in,
  input  logic [`CORE_INST_WIDTH-1:0] i_inst,
  input  logic [`CORE_PC_WIDTH-1:0]   i_pc,
  input  logic                        i_branch_jump_predict,
  input  logic                        i_pipe_flush_req,
  output logic                        valid_out,
  input  logic                        ready_out,
  output logic [`CORE_INST_WIDTH-1:0] o_inst,
  output logic [`CORE_PC_WIDTH-1:0]   o_pc,
  output logic                        o_branch_jump_predict,
  output logic [$clog2(DEPTH):0]      o_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef logic [AW:0] ptr_t;

  ibuf_entry_t mem_q [DEPTH];
  ptr_t        rptr_q, wptr_q;
  ptr_t        count;
  ibuf_entry_t in_entry, head, out_entry;
  logic        empty, full, push, pop;
`ifdef CORE_IBUF_BYPASS_EN
  logic        bypass;
`endif

  always_comb begin
    // Pointers carry an extra MSB so that full and empty differ in the difference.
    count    = wptr_q - rptr_q;
    empty    = (count == '0);
    full     = (count == ptr_t'(DEPTH));
    ready_in = ~full | ready_out;
    in_entry = make_entry(i_inst, i_pc, i_branch_jump_predict);
    head     = mem_q[rptr_q[AW-1:0]];

    valid_out = ~empty & ~i_pipe_flush_req;
    out_entry = head;
    push      = valid_in & ready_in & ~i_pipe_flush_req;
`ifdef CORE_IBUF_BYPASS_EN
    bypass = empty & valid_in & ~i_pipe_flush_req;
    if (bypass) begin
      valid_out = 1'b1;
      out_entry = in_entry;
      // A bypassed packet taken by decode this cycle never enters storage.
      if (ready_out) begin
        push = 1'b0;
      end
    end
`endif
    pop = valid_out & ready_out & ~empty;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr_q <= '0;
      wptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (i_pipe_flush_req) begin
      rptr_q <= '0;
      wptr_q <= '0;
    end else begin
      if (push) begin
        mem_q[wptr_q[AW-1:0]] <= in_entry;
        wptr_q                <= wptr_q + ptr_t'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + ptr_t'(1);
      end
    end
  end

  assign o_inst                = out_entry.inst;
  assign o_pc                  = out_entry.pc;
  assign o_branch_jump_predict = out_entry.predict;
  assign o_count               = count;

endmodule

// File: tb/tb_core_if_ibuf.sv
// Self-checking bench for core_if_ibuf: directed vector table, hand-written corner
// sequences and a randomized run against a queue-based reference model (DEPTH 2 and 4).
module tb_core_if_ibuf;
  import core_if_ibuf_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 valid_in, ready_out, flush, pred;
  logic [InstWidth-1:0] inst;
  logic [PcWidth-1:0]   pc;

  logic                 ri2, vo2, p2, ri4, vo4, p4;
  logic [InstWidth-1:0] oi2, oi4;
  logic [PcWidth-1:0]   opc2, opc4;
  logic [1:0]           cnt2;
  logic [2:0]           cnt4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  core_if_ibuf #(.DEPTH(2)) u_dut2 (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_in(ri2), .i_inst(inst), .i_pc(pc),
    .i_branch_jump_predict(pred), .i_pipe_flush_req(flush), .valid_out(vo2),
    .ready_out(ready_out), .o_inst(oi2), .o_pc(opc2), .o_branch_jump_predict(p2),
    .o_count(cnt2)
  );

  core_if_ibuf #(.DEPTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_in(ri4), .i_inst(inst), .i_pc(pc),
    .i_branch_jump_predict(pred), .i_pipe_flush_req(flush), .valid_out(vo4),
    .ready_out(ready_out), .o_inst(oi4), .o_pc(opc4), .o_branch_jump_predict(p4),
    .o_count(cnt4)
  );

  typedef struct {
    logic               vi, ro, fl;
    logic [PcWidth-1:0] pc;
    logic               evo, eri;
    logic [1:0]         ecnt;
    logic               chk;
    logic [PcWidth-1:0] epc;
  } vec_t;

  vec_t        tbl[13];
  ibuf_entry_t q2[$];
  ibuf_entry_t q4[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic vi, ro, fl, input logic [PcWidth-1:0] p,
                              input logic evo, eri, input logic [1:0] ecnt, input logic chk,
                              input logic [PcWidth-1:0] epc);
    vec_t v;
    v.vi = vi; v.ro = ro; v.fl = fl; v.pc = p;
    v.evo = evo; v.eri = eri; v.ecnt = ecnt; v.chk = chk; v.epc = epc;
    return v;
  endfunction

  task automatic idle_inputs();
    valid_in = 1'b0; ready_out = 1'b0; flush = 1'b0; pred = 1'b0; pc = '0; inst = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Checks one DUT against the model state and returns the expected handshake values.
  task automatic model_check(input string tag, input int depth, input ibuf_entry_t q_head,
                             input int size, input logic act_vo, act_ri,
                             input logic [7:0] act_cnt, input ibuf_entry_t act_e,
                             output logic exp_vo, output logic exp_ri, output logic byp);
    ibuf_entry_t cur;
    cur = make_entry(inst, pc, pred);
    byp = 1'b0;
`ifdef CORE_IBUF_BYPASS_EN
    byp = (size == 0) && valid_in && !flush;
`endif
    exp_ri = (size != depth) || ready_out;
    exp_vo = ((size != 0) || byp) && !flush;
    check({tag, " count"}, act_cnt, 8'(size));
    check({tag, " ready_in"}, act_ri, exp_ri);
    check({tag, " valid_out"}, act_vo, exp_vo);
    if (exp_vo) check({tag, " head"}, act_e, byp ? cur : q_head);
  endtask

  task automatic random_cycle();
    logic        evo2, eri2, byp2, evo4, eri4, byp4;
    ibuf_entry_t cur, h2, h4;
    flush     = ($urandom_range(0, 19) == 0);
    valid_in  = ($urandom_range(0, 9) < 7);
    ready_out = ($urandom_range(0, 9) < 6);
    pc        = PcWidth'($urandom);
    inst      = InstWidth'($urandom);
    pred      = 1'($urandom);
    cur       = make_entry(inst, pc, pred);
    @(negedge clk);
    h2 = (q2.size() > 0) ? q2[0] : '0;
    h4 = (q4.size() > 0) ? q4[0] : '0;
    model_check("rnd d2", 2, h2, q2.size(), vo2, ri2, 8'(cnt2), make_entry(oi2, opc2, p2),
                evo2, eri2, byp2);
    model_check("rnd d4", 4, h4, q4.size(), vo4, ri4, 8'(cnt4), make_entry(oi4, opc4, p4),
                evo4, eri4, byp4);
    if (flush) begin
      q2.delete();
      q4.delete();
    end else begin
      if (!(byp2 && ready_out)) begin
        if (evo2 && ready_out) void'(q2.pop_front());
        if (valid_in && eri2) q2.push_back(cur);
      end
      if (!(byp4 && ready_out)) begin
        if (evo4 && ready_out) void'(q4.pop_front());
        if (valid_in && eri4) q4.push_back(cur);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    #3;
    check("reset d2", {vo2, ri2, cnt2, oi2, opc2, p2}, {1'b0, 1'b1, 2'd0, 65'd0});
    check("reset d4", {vo4, ri4, cnt4, oi4, opc4, p4}, {1'b0, 1'b1, 3'd0, 65'd0});
    @(posedge clk);
    #1 rst = 1'b0;

`ifndef CORE_IBUF_BYPASS_EN
    tbl[0]  = mk(1, 1, 0, 32'h8000_0000, 0, 1, 2'd0, 0, 32'h0);
    tbl[1]  = mk(0, 1, 0, 32'h0,         1, 1, 2'd1, 1, 32'h8000_0000);
    tbl[2]  = mk(0, 1, 0, 32'h0,         0, 1, 2'd0, 0, 32'h0);
    tbl[3]  = mk(1, 0, 0, 32'h0,         0, 1, 2'd0, 0, 32'h0);
    tbl[4]  = mk(1, 0, 0, 32'h4,         1, 1, 2'd1, 1, 32'h0);
    tbl[5]  = mk(1, 0, 0, 32'h8,         1, 0, 2'd2, 1, 32'h0);
    tbl[6]  = mk(1, 0, 0, 32'h8,         1, 0, 2'd2, 1, 32'h0);
    tbl[7]  = mk(1, 1, 0, 32'h8,         1, 1, 2'd2, 1, 32'h0);
    tbl[8]  = mk(0, 0, 0, 32'h0,         1, 0, 2'd2, 1, 32'h4);
    tbl[9]  = mk(0, 1, 0, 32'h0,         1, 1, 2'd2, 1, 32'h4);
    tbl[10] = mk(0, 0, 0, 32'h0,         1, 1, 2'd1, 1, 32'h8);
    tbl[11] = mk(1, 1, 1, 32'hc,         0, 1, 2'd1, 0, 32'h0);
    tbl[12] = mk(0, 0, 0, 32'h0,         0, 1, 2'd0, 0, 32'h0);
    for (int i = 0; i < 13; i++) begin
      valid_in = tbl[i].vi; ready_out = tbl[i].ro; flush = tbl[i].fl;
      pc = tbl[i].pc; inst = 32'h13; pred = 1'b0;
      @(negedge clk);
      check($sformatf("vec%0d hs", i), {vo2, ri2, cnt2}, {tbl[i].evo, tbl[i].eri, tbl[i].ecnt});
      if (tbl[i].chk) check($sformatf("vec%0d data", i), {opc2, oi2}, {tbl[i].epc, 32'h13});
      @(posedge clk);
      #1;
    end
`else
    do_reset();
    valid_in = 1'b1; ready_out = 1'b1; pc = 32'h100; inst = 32'h13;
    #1;
    check("bypass same cycle", {vo2, opc2, cnt2}, {1'b1, 32'h100, 2'd0});
    @(posedge clk);
    #1 idle_inputs();
    @(negedge clk);
    check("bypass not stored", {vo2, cnt2}, {1'b0, 2'd0});
    flush = 1'b1; valid_in = 1'b1; ready_out = 1'b1;
    #1;
    check("bypass flush", vo2, 1'b0);
    @(posedge clk);
    #1 idle_inputs();
`endif

    // Flush with three entries resident and a concurrent push.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      valid_in = 1'b1; pc = PcWidth'(32'h10 + 4 * i);
      @(posedge clk);
      #1;
    end
    valid_in = 1'b0;
    @(negedge clk);
    check("d4 three entries", {vo4, cnt4, opc4}, {1'b1, 3'd3, 32'h10});
    @(posedge clk);
    #1 flush = 1'b1; valid_in = 1'b1; ready_out = 1'b1; pc = 32'h40;
    @(negedge clk);
    check("d4 flush valid", vo4, 1'b0);
    @(posedge clk);
    #1 idle_inputs();
    @(negedge clk);
    check("d4 after flush", {vo4, cnt4}, {1'b0, 3'd0});
    @(posedge clk);
    #1;
    @(negedge clk);
    check("d4 flush dropped push", {vo4, cnt4}, {1'b0, 3'd0});

    // Asynchronous reset while two entries are held.
    do_reset();
    for (int i = 0; i < 2; i++) begin
      valid_in = 1'b1; pc = PcWidth'(32'h200 + 4 * i);
      @(posedge clk);
      #1;
    end
    valid_in = 1'b0;
    @(negedge clk);
    check("d2 full before rst", cnt2, 2'd2);
    #1 rst = 1'b1;
    #1;
    check("async rst d2", {vo2, ri2, cnt2, opc2}, {1'b0, 1'b1, 2'd0, 32'h0});
    @(posedge clk);
    #1 rst = 1'b0;

    do_reset();
    q2.delete();
    q4.delete();
    for (int i = 0; i < 1500; i++) random_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
